// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver
//   Receives 8E1 serial frames (start, 8 data bits LSB first, even parity,
//   stop) using 16x oversampling and 2-of-3 majority voting per bit.
//
// Ports
//   clk          in   system clock (50 MHz nominal)
//   reset        in   asynchronous, active-low reset
//   baud_select  in   rate select 0..7 (300 .. 115200 baud), latched per frame
//   Rx_EN        in   receiver enable; low aborts any frame in progress
//   RxD          in   serial line, asynchronous to clk, idle high
//   Rx_DATA      out  last received byte
//   Rx_VALID     out  one-clk pulse at frame completion
//   Rx_PERROR    out  parity error flag of the last frame
//   Rx_FERROR    out  framing error flag of the last frame
//   Rx_BUSY      out  high while a frame is in progress
module uart_receiver (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_BUSY
);

  localparam int unsigned DIV_W  = 14;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BAUD_W = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                r_rxd_meta;
  logic                r_rxd_sync;
  logic                r_armed;
  logic [BAUD_W-1:0]   r_baud;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    w_div_max;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic                r_smp7;
  logic                r_smp8;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;

  logic                w_tick;
  logic                w_wrap;
  logic                w_vote_tick;
  logic                w_vote;
  logic                w_start;
  logic                w_done;

  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= RxD;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  // Divider terminal count (divisor - 1) for the baud rate latched at start
  always_comb begin
    w_div_max = DIV_W'(26);
    case (r_baud)
      3'd0:    w_div_max = DIV_W'(10416);
      3'd1:    w_div_max = DIV_W'(2603);
      3'd2:    w_div_max = DIV_W'(650);
      3'd3:    w_div_max = DIV_W'(325);
      3'd4:    w_div_max = DIV_W'(162);
      3'd5:    w_div_max = DIV_W'(80);
      3'd6:    w_div_max = DIV_W'(53);
      default: w_div_max = DIV_W'(26);
    endcase
  end

  // Tick pulse N (N = 1..16 after the start edge) fires while the tick
  // counter still holds N-1, so ticks 7/8/9 are seen at counts 6/7/8.
  assign w_tick      = (r_state != S_IDLE) && (r_div == w_div_max);
  assign w_wrap      = w_tick && (r_tick_cnt == TICK_W'(15));
  assign w_vote_tick = w_tick && (r_tick_cnt == TICK_W'(8));

  // 2-of-3 majority over ticks 7, 8 and the live sample at tick 9
  assign w_vote = (r_smp7 & r_smp8) | (r_smp7 & r_rxd_sync) | (r_smp8 & r_rxd_sync);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; Rx_EN low overrides everything
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    if (!Rx_EN) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_armed && !r_rxd_sync) begin
            w_start      = 1'b1;
            w_state_next = S_START;
          end
        end
        S_START: begin
          if (w_vote_tick && w_vote) begin
            w_state_next = S_IDLE;
          end else if (w_wrap) begin
            w_state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (w_wrap && (r_bit_cnt == BIT_W'(7))) begin
            w_state_next = S_PARITY;
          end
        end
        S_PARITY: begin
          if (w_wrap) begin
            w_state_next = S_STOP;
          end
        end
        S_STOP: begin
          if (w_vote_tick) begin
            w_done       = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Armed means the line was high on the previous clk while idle and enabled,
  // so a low now is a genuine 1->0 edge; a line stuck low never re-arms.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed <= 1'b0;
    end else if ((r_state == S_IDLE) && (w_state_next == S_IDLE) && Rx_EN) begin
      r_armed <= r_rxd_sync;
    end else begin
      r_armed <= 1'b0;
    end
  end

  // Divider, tick and bit counters; cleared at the start edge and while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud     <= '0;
      r_div      <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_start) begin
      r_baud     <= baud_select;
      r_div      <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if ((r_state == S_IDLE) || (w_state_next == S_IDLE)) begin
      r_div      <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_tick) begin
      r_div      <= '0;
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      if (w_wrap && (r_state == S_DATA)) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Bit sampling, data shift register and parity capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_smp7  <= 1'b1;
      r_smp8  <= 1'b1;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      if (w_tick && (r_tick_cnt == TICK_W'(6))) begin
        r_smp7 <= r_rxd_sync;
      end
      if (w_tick && (r_tick_cnt == TICK_W'(7))) begin
        r_smp8 <= r_rxd_sync;
      end
      if (w_vote_tick && (r_state == S_DATA)) begin
        r_shift <= {w_vote, r_shift[DATA_W-1:1]};
      end
      if (w_vote_tick && (r_state == S_PARITY)) begin
        r_par <= w_vote;
      end
    end
  end

  // Registered outputs; data and flags only move on a completed frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
      Rx_BUSY   <= 1'b0;
    end else begin
      Rx_VALID <= w_done;
      Rx_BUSY  <= (w_state_next != S_IDLE);
      if (w_done) begin
        Rx_DATA   <= r_shift;
        Rx_PERROR <= (^r_shift) ^ r_par;
        Rx_FERROR <= ~w_vote;
      end
    end
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have port clk, input, 1, system clock, 50 MHz nominal.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-003 SHALL have port baud_select, input, 3, rate select, same encoding as the transmitter.
REQ-004 SHALL have port Rx_EN, input, 1, receiver enable.
REQ-005 SHALL have port RxD, input, 1, serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port Rx_DATA, output, 8, last received byte.
REQ-007 SHALL have port Rx_VALID, output, 1, one-clk pulse at frame completion.
REQ-008 SHALL have port Rx_PERROR, output, 1, parity error flag of the last frame.
REQ-009 SHALL have port Rx_FERROR, output, 1, framing error flag of the last frame.
REQ-010 SHALL have port Rx_BUSY, output, 1, high while a frame is in progress.

Function
REQ-011 SHALL pass RxD through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-012 SHALL generate a 16x oversample tick, one clk wide, from a clk divider; divisor per baud_select 0..7: 10417, 2604, 651, 326, 163, 81, 54, 27 (300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud).
REQ-013 SHALL latch baud_select on start-edge detection; changes mid-frame SHALL NOT affect the current frame.
REQ-014 SHALL clear the divider and the 4-bit tick counter on start-edge detection, so tick 0 aligns to the falling edge.
REQ-015 SHALL use frame format: start(0), 8 data bits LSB first, even parity bit (XOR of the 8 data bits), stop(1).
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE SHALL wait for arming: synchronized RxD seen high for at least one clk; a 1->0 transition while armed and Rx_EN=1 moves the FSM to START.
REQ-018 SHALL sample each bit by 2-of-3 majority vote of the synchronized RxD at ticks 7, 8, 9.
REQ-019 START SHALL go to DATA if the start-bit vote is 0; if the vote is 1 (glitch), it SHALL return to IDLE with no output change.
REQ-020 DATA SHALL shift 8 voted bits LSB first using a 3-bit bit counter, then go to PARITY.
REQ-021 PARITY SHALL capture the voted parity bit, then go to STOP.
REQ-022 STOP SHALL vote the stop bit; at tick 9 it SHALL return to IDLE.
REQ-023 At the clk after the stop-bit vote, Rx_DATA, Rx_PERROR and Rx_FERROR SHALL update and Rx_VALID SHALL pulse high for exactly one clk.
REQ-024 Rx_PERROR SHALL be set to (XOR of data) XOR parity bit.
REQ-025 Rx_FERROR SHALL be set to NOT stop bit.
REQ-026 A frame with errors SHALL still update Rx_DATA and pulse Rx_VALID.
REQ-027 After a framing error, the FSM SHALL re-arm only after synchronized RxD returns high (break: no repeated frames).
REQ-028 Rx_DATA and the error flags SHALL hold between frames; they change only at the Rx_VALID pulse.
REQ-029 Rx_BUSY SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-030 Rx_EN=0 SHALL force IDLE within one clk and abort any partial frame with no Rx_VALID; outputs SHALL hold their values.
REQ-031 The divider and tick counter SHALL wrap modulo divisor and 16 respectively, with no overflow past these bounds.

Reset
REQ-032 On reset low, asynchronously: FSM=IDLE (unarmed), counters=0, synchronizer flops=1, Rx_DATA=0x00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, Rx_BUSY=0.
REQ-033 Reset asserted mid-frame SHALL discard the frame; after release, no Rx_VALID until a complete new frame is received.

Verification
REQ-034 Correct frame: baud_select=7, Rx_EN=1, frame 0x55 with parity 0 and stop 1 -> one Rx_VALID pulse, Rx_DATA=0x55, PERROR=0, FERROR=0.
REQ-035 Parity error: frame 0xA3 with parity bit 1 -> Rx_DATA=0xA3, PERROR=1, FERROR=0, Rx_VALID pulses.
REQ-036 Framing error then break: frame 0x0F with stop=0, line held low for 3 bit times -> FERROR=1, exactly one Rx_VALID; the next good frame 0x3C is received with FERROR=0.
REQ-037 Glitch rejection: RxD low for 4 oversample ticks, then high -> Rx_BUSY pulses, no Rx_VALID, Rx_DATA unchanged.
REQ-038 Abort: Rx_EN deasserted during data bit 4, then reset asserted mid-frame on a second frame -> no Rx_VALID, Rx_BUSY=0 within one clk; the following 0xFF frame is received correctly.
REQ-039 Rate sweep: 0xC6 sent at baud_select 0..7, with ±2% transmitter rate error at 7 -> all received correctly; a baud_select change mid-frame does not corrupt the frame.
